// File: rtl/gf2_poly_reducer_pkg.sv
// Shared constants, state encoding and parameter checks for the GF(2)[x] reducer.
package gf2_pkg;

    localparam int unsigned DEF_N    = 3;
    localparam logic [3:0]  DEF_POLY = 4'b1011;

    function automatic int unsigned prod_width(input int unsigned n);
        return 2 * n - 1;
    endfunction

    localparam int unsigned DEF_W = prod_width(DEF_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Modulus must be monic of degree n, and n must leave at least one reduction step.
    function automatic bit params_ok(input int unsigned n, input logic [63:0] poly);
        return (n >= 2) && (poly[n] == 1'b1);
    endfunction

endpackage

// File: rtl/gf2_poly_reducer_step.sv
// One shift-XOR reduction step: clears bit idx of r using POLY aligned to that bit.
module gf2_reduce_step
    import gf2_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned W    = prod_width(N),
    parameter int unsigned IDXW = $clog2(W)
) (
    input  logic [W-1:0]    r,
    input  logic [IDXW-1:0] idx,
    input  logic [N:0]      poly,
    output logic [W-1:0]    r_next
);

    always_comb begin
        r_next = r;
        if ((idx >= IDXW'(N)) && r[idx]) begin
            r_next = r ^ (W'(poly) << (idx - IDXW'(N)));
        end
    end

endmodule

// File: rtl/gf2_poly_reducer.sv
// Sequential reduction of a carry-less product modulo a fixed monic POLY,
// one bit per cycle from the top, with valid/ready on both sides.
module gf2_poly_reducer
    import gf2_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter logic [N:0]  POLY = DEF_POLY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [prod_width(N)-1:0] in_prod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_rem,
    output logic                     busy
);

    localparam int unsigned W    = prod_width(N);
    localparam int unsigned IDXW = $clog2(W);

    if (!params_ok(N, 64'(POLY))) begin : g_bad_params
        $error("gf2_poly_reducer: N must be >= 2 and POLY[N] must be 1");
    end

    state_t          state, state_n;
    logic [W-1:0]    r, r_n, r_step;
    logic [IDXW-1:0] idx, idx_n;
    logic            accept;

    gf2_reduce_step #(
        .N    (N),
        .W    (W),
        .IDXW (IDXW)
    ) u_step (
        .r      (r),
        .idx    (idx),
        .poly   (POLY),
        .r_next (r_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            r     <= r_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        r_n       = r;
        idx_n     = idx;
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept    = in_valid && in_ready;
        out_valid = (state == DONE);
        out_rem   = '0;
        busy      = (state != IDLE);

        case (state)
            IDLE: ;
            RUN: begin
                r_n   = r_step;
                idx_n = idx - IDXW'(1);
                if (idx == IDXW'(N)) state_n = DONE;
            end
            DONE: begin
                out_rem = r[N-1:0];
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A load from DONE overrides the return to IDLE: output and input handshakes share the edge.
        if (accept) begin
            r_n     = in_prod;
            idx_n   = IDXW'(W - 1);
            state_n = RUN;
        end
    end

endmodule

// File: tb/tb_gf2_poly_reducer.sv
// Scoreboard bench for gf2_poly_reducer (N=3, POLY=x^3+x+1) with hand-computed remainders.
module tb_gf2_poly_reducer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_prod;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_rem;
    logic       busy;

    gf2_poly_reducer #(
        .N    (3),
        .POLY (4'b1011)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [2:0]  expq[$];
    int unsigned nvec = 0;
    int unsigned nerr = 0;
    longint      acc_t;
    bit          ok;

    // Monitor: pops one expected remainder per completed output handshake.
    always @(negedge clk) begin
        logic [2:0] ev;
        #2;
        if (!rst && out_valid && out_ready) begin
            nvec++;
            if (expq.size() == 0) begin
                nerr++;
                $display("FAIL rem_unexpected got=%b required=none", out_rem);
            end else begin
                ev = expq.pop_front();
                if (out_rem !== ev) begin
                    nerr++;
                    $display("FAIL rem got=%b required=%b", out_rem, ev);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s got=%0d required=%0d", nm, act, req);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [4:0] p, input logic [2:0] e, input bit push, output bit acc);
        acc      = 1'b0;
        in_valid = 1'b1;
        in_prod  = p;
        for (int t = 0; t < 40 && !acc; t++) begin
            #1;
            if (in_ready) begin
                acc = 1'b1;
                if (push) expq.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        if (acc) begin
            @(posedge clk);
            acc_t = $time;
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && expq.size() != 0; t++) @(negedge clk);
        chk("drain_pending", expq.size(), 0);
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            seen = out_valid;
            if (!seen) @(negedge clk);
        end
        chk("valid_timeout", 32'(seen), 1);
    endtask

    function automatic logic [4:0] clmul3(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] pr = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                pr[i+j] ^= a[i] & b[j];
        return pr;
    endfunction

    logic [4:0] s_prod [8] = '{5'b10110, 5'b01101, 5'b11010, 5'b00001,
                               5'b10001, 5'b11100, 5'b01011, 5'b10011};
    logic [2:0] s_rem  [8] = '{3'b000, 3'b110, 3'b111, 3'b001,
                               3'b111, 3'b001, 3'b000, 3'b101};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint prev_t;
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
        @(negedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_rem", 32'(out_rem), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 1);

        // No in_valid: out_ready alone must not move the FSM.
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_out_valid", 32'(out_valid), 0);
        @(negedge clk);

        // Latency: accept edge 0, result visible after edge 2.
        send(5'b10101, 3'b011, 1'b1, ok);
        #1;
        chk("lat_busy_e0", 32'(busy), 1);
        chk("lat_valid_e0", 32'(out_valid), 0);
        @(negedge clk); #1 chk("lat_valid_e1", 32'(out_valid), 0);
        @(negedge clk); #1;
        chk("lat_valid_e2", 32'(out_valid), 1);
        chk("lat_rem_e2", 32'(out_rem), 32'b011);
        @(negedge clk);

        send(5'b11111, 3'b010, 1'b1, ok);
        send(5'b00000, 3'b000, 1'b1, ok);
        send(5'b00111, 3'b111, 1'b1, ok);
        send(5'b01000, 3'b011, 1'b1, ok);
        send(clmul3(3'b111, 3'b111), 3'b011, 1'b1, ok);
        drain();

        // Back-pressure: hold DONE, then release together with a new product.
        out_ready = 1'b0;
        send(5'b10101, 3'b011, 1'b1, ok);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_rem", 32'(out_rem), 32'b011);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(5'b11111, 3'b010, 1'b1, ok);
        #1;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        drain();

        // Streaming: accepts must land exactly three cycles apart.
        prev_t = 0;
        for (int i = 0; i < 8; i++) begin
            send(s_prod[i], s_rem[i], 1'b1, ok);
            if (i > 0) chk("stream_gap", 32'(acc_t - prev_t), 30);
            prev_t = acc_t;
        end
        drain();

        // Asynchronous reset while a result is being held in DONE.
        out_ready = 1'b0;
        send(5'b01101, 3'b000, 1'b0, ok);
        wait_valid();
        rst = 1'b1;
        #1;
        chk("rstdone_out_valid", 32'(out_valid), 0);
        chk("rstdone_out_rem", 32'(out_rem), 0);
        chk("rstdone_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstdone_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        // Reset one cycle after accepting, mid-RUN; the aborted product must never appear.
        out_ready = 1'b1;
        send(5'b11111, 3'b000, 1'b0, ok);
        rst = 1'b1;
        #1;
        chk("rstrun_out_valid", 32'(out_valid), 0);
        chk("rstrun_out_rem", 32'(out_rem), 0);
        chk("rstrun_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstrun_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        send(5'b10101, 3'b011, 1'b1, ok);
        drain();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gf2_poly_reducer.md
Name: gf2_poly_reducer

Overview:
- Sequential modular-reduction stage downstream of the ks-series carry-less Karatsuba multipliers (ks3 for N=3).
- Takes a (2N-1)-bit GF(2)[x] product and reduces it modulo a fixed monic degree-N polynomial POLY, one shift-XOR step per cycle.
- Returns the N-bit remainder.
- Valid/ready handshakes on both sides, so it can sit between a combinational multiplier and a registered consumer.

Parameters:
N, 3, operand degree bound; product width W=2N-1, remainder width N; must be >=2 (elaboration error otherwise)
POLY, 4'b1011, (N+1)-bit monic modulus (x^3+x+1 by default); POLY[N] must be 1 (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_prod holds a product to reduce
in_ready  output  1  block can accept in_prod this cycle
in_prod  input  2N-1  carry-less product, bit i = coefficient of x^i
out_valid  output  1  out_rem holds a finished remainder
out_ready  input  1  consumer accepts out_rem this cycle
out_rem  output  N  in_prod mod POLY
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, any state, including mid-RUN):
  - state=IDLE, working register r=0, step counter idx=0.
  - out_valid=0, out_rem=0, busy=0, in_ready=1 once rst deasserts.
  - Any in-flight transaction is discarded; nothing is emitted for it.
- States: IDLE, RUN, DONE (encoding from package).
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready; documented and accepted.
- Accept: on an edge with in_valid & in_ready:
  - r <= in_prod, idx <= W-1, state <= RUN.
  - Same edge from DONE: the output handshake completes and the new load happens together (back-to-back).
- RUN, each edge:
  - if r[idx]=1 then r <= r ^ (POLY << (idx-N)).
  - idx <= idx-1.
  - On the edge processing idx==N, state <= DONE.
  - Exactly N-1 RUN edges; in_valid ignored during RUN.
- DONE:
  - out_valid=1, out_rem=r[N-1:0]; r[W-1:N] is guaranteed 0.
  - Outputs held stable while out_ready=0.
  - On out_ready=1 edge: state <= IDLE, or RUN if a new accept happens on the same edge.
- out_rem is driven 0 whenever out_valid=0.
- Latency: accept at edge 0, out_valid high after edge N-1 (for N=3: accept edge 0, RUN edges 1-2, out_valid after edge 2).
- Throughput: one result per N cycles with out_ready held high.
- Arithmetic: pure GF(2), XOR only, no carries. Remainder is the unique degree<N polynomial congruent to in_prod.
- Boundary cases:
  - in_prod=0 gives 0.
  - in_prod with no bits at or above N passes through unchanged (still N-1 cycle latency).
  - out_ready high outside DONE has no effect.
  - in_valid deasserted before acceptance: no state change.

Decomposition:
- Shared package gf2_pkg holds:
  - default N and POLY constants, W as a localparam function of N;
  - state enum IDLE/RUN/DONE;
  - the elaboration checks for N>=2 and POLY[N]==1.
- One sub-module is natural: gf2_reduce_step. It is combinational and takes r, idx and POLY; it returns r conditionally XORed with the shifted POLY. Instantiated once. The FSM, counter and handshake stay in the top.

Test Plan:
- Basic reduction (N=3): in_prod=5'b10101 with out_ready=1 -> out_valid after 2 RUN cycles, out_rem=3'b011. Also in_prod=5'b11111 -> out_rem=3'b010.
- Boundary values: in_prod=5'b00000 -> 3'b000; in_prod=5'b00111 -> 3'b111; in_prod=5'b01000 -> 3'b011.
- End-to-end with ks3: a=3'b111, b=3'b111, ks3 product 5'b10101 fed in -> out_rem=3'b011.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_rem stable at 3'b011, in_ready=0. Raise out_ready with a new in_valid -> back-to-back accept on that edge.
- Streaming: 8 random products with in_valid and out_ready always 1 -> one result every 3 cycles, each matching a software GF(2) mod-0b1011 model, in order.
- Reset mid-RUN: assert rst one cycle after accepting 5'b11111 -> out_valid=0, out_rem=0, busy=0 immediately (async). After release in_ready=1, and the next product 5'b10101 yields 3'b011 with no stale output.
